// File: rtl/column_queue.sv
// Store-mapped column FIFO: datapath stores push wall distances tagged with a
// wrapping screen column index; the column renderer drains via valid/ready.
module column_queue #(
    parameter logic [15:0] BASE_ADDRESS = 16'hFF00,
    parameter int          DEPTH        = 16,
    parameter int          COLUMN_COUNT = 320,
    parameter int          COLUMN_WIDTH = 9
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             memory_address,
    input  logic [15:0]             memory_write_data,
    input  logic                    memory_write_enable,
    output logic                    io_select,
    output logic [15:0]             io_read_data,
    output logic                    col_valid,
    input  logic                    col_ready,
    output logic [15:0]             col_distance,
    output logic [COLUMN_WIDTH-1:0] col_index
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = COLUMN_WIDTH + 16;

    logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [COLUMN_WIDTH-1:0] col_q, col_d;
    logic                    ovf_q, ovf_d;
    logic                    io_select_q;
    logic [15:0]             io_read_data_q, io_read_data_d;
    logic [EW-1:0]           mem [DEPTH];

    logic [15:0] offset;
    logic        in_win, wr_hit;
    logic        push_req, push_ok, pop, clr_ovf, col_clr, flush;
    logic        full, empty;

    // Unsigned wraparound makes addresses below the base fall outside the window.
    assign offset   = memory_address - BASE_ADDRESS;
    assign in_win   = (offset < 16'd4);
    assign wr_hit   = memory_write_enable & in_win;
    assign push_req = wr_hit & (offset[1:0] == 2'd0);
    assign clr_ovf  = wr_hit & (offset[1:0] == 2'd1);
    assign col_clr  = wr_hit & (offset[1:0] == 2'd2);
    assign flush    = col_clr & memory_write_data[0];

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign pop      = col_valid & col_ready;
    assign push_ok  = push_req & (!full | pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        col_d    = col_q;
        ovf_d    = ovf_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            col_d    = (col_q == COLUMN_WIDTH'(COLUMN_COUNT - 1)) ? '0 : col_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (push_req && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (clr_ovf) begin
            ovf_d = 1'b0;
        end
        if (col_clr) begin
            col_d = '0;
        end
        // Flush overrides a same-cycle pop; a push cannot coincide with it.
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_comb begin
        io_read_data_d = '0;
        if (in_win) begin
            case (offset[1:0])
                2'd1:    io_read_data_d = {ovf_q, full, empty, 13'(count_q)};
                2'd3:    io_read_data_d = 16'(col_q);
                default: io_read_data_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            col_q          <= '0;
            ovf_q          <= 1'b0;
            io_select_q    <= 1'b0;
            io_read_data_q <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            col_q          <= col_d;
            ovf_q          <= ovf_d;
            io_select_q    <= in_win;
            io_read_data_q <= io_read_data_d;
        end
    end

    // Storage needs no reset: col_valid comes from the count alone.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {col_q, memory_write_data};
        end
    end

    assign io_select    = io_select_q;
    assign io_read_data = io_read_data_q;
    assign col_valid    = !empty;
    assign col_distance = mem[rd_ptr_q][15:0];
    assign col_index    = mem[rd_ptr_q][EW-1:16];

endmodule

// File: tb/tb_column_queue.sv
// Bench for column_queue: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_column_queue;

    localparam logic [15:0] BASE = 16'hFF00;
    localparam int DEPTH = 16;
    localparam int COLS  = 320;
    localparam int CWID  = 9;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic [15:0]     memory_address = '0;
    logic [15:0]     memory_write_data = '0;
    logic            memory_write_enable = 1'b0;
    logic            io_select;
    logic [15:0]     io_read_data;
    logic            col_valid;
    logic            col_ready = 1'b0;
    logic [15:0]     col_distance;
    logic [CWID-1:0] col_index;

    int checks = 0;
    int failures = 0;

    column_queue #(
        .BASE_ADDRESS(BASE),
        .DEPTH(DEPTH),
        .COLUMN_COUNT(COLS),
        .COLUMN_WIDTH(CWID)
    ) dut (
        .clock(clock),
        .reset(reset),
        .memory_address(memory_address),
        .memory_write_data(memory_write_data),
        .memory_write_enable(memory_write_enable),
        .io_select(io_select),
        .io_read_data(io_read_data),
        .col_valid(col_valid),
        .col_ready(col_ready),
        .col_distance(col_distance),
        .col_index(col_index)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of {tag, distance} entries.
    logic [24:0] m_q[$];
    int          m_col = 0;
    bit          m_ovf = 0;
    bit          m_sel = 0;
    logic [15:0] m_rd = '0;

    always @(posedge clock or posedge reset) begin
        int  off;
        bit  inwin, wr, pop;
        if (reset) begin
            m_q.delete();
            m_col = 0;
            m_ovf = 0;
            m_sel = 0;
            m_rd  = '0;
        end else begin
            inwin = (memory_address >= BASE) && (memory_address <= BASE + 16'd3);
            off   = int'(memory_address) - int'(BASE);
            m_sel = inwin;
            m_rd  = '0;
            if (inwin && off == 1)
                m_rd = {m_ovf, m_q.size() == DEPTH, m_q.size() == 0, 13'(m_q.size())};
            if (inwin && off == 3)
                m_rd = 16'(m_col);
            pop = (m_q.size() != 0) && col_ready;
            wr  = memory_write_enable && inwin;
            if (pop) void'(m_q.pop_front());
            if (wr && off == 0) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({CWID'(m_col), memory_write_data});
                    m_col = (m_col + 1) % COLS;
                end else begin
                    m_ovf = 1;
                end
            end
            if (wr && off == 1) m_ovf = 0;
            if (wr && off == 2) begin
                m_col = 0;
                if (memory_write_data[0]) m_q.delete();
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            check("col_valid", col_valid, m_q.size() != 0);
            if (m_q.size() != 0) begin
                check("col_distance", col_distance, m_q[0][15:0]);
                check("col_index", col_index, m_q[0][24:16]);
            end
            check("io_select", io_select, m_sel);
            check("io_read_data", io_read_data, m_rd);
        end
    end

    task automatic wr(input int off, input logic [15:0] data);
        memory_address      = BASE + 16'(off);
        memory_write_data   = data;
        memory_write_enable = 1'b1;
        @(posedge clock); #1;
        memory_write_enable = 1'b0;
        memory_address      = '0;
    endtask

    task automatic rd(input string name, input int off, input logic [15:0] exp);
        memory_address      = BASE + 16'(off);
        memory_write_enable = 1'b0;
        @(posedge clock); #1;
        check({name, "_sel"}, io_select, 1'b1);
        check(name, io_read_data, exp);
        memory_address = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_valid", col_valid, 1'b0);
        check("rst_sel", io_select, 1'b0);
        check("rst_rdata", io_read_data, 16'h0000);
        reset = 1'b0;
        @(posedge clock); #1;
        rd("idle_status", 1, 16'h2000);

        // Push three, then drain
        wr(0, 16'd100);
        wr(0, 16'd200);
        wr(0, 16'd300);
        check("head_valid", col_valid, 1'b1);
        check("head_dist", col_distance, 16'd100);
        check("head_idx", col_index, 9'd0);
        rd("status3", 1, 16'h0003);
        col_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("drain_idx", col_index, 9'(i));
            check("drain_dist", col_distance, 16'(100 * (i + 1)));
            @(posedge clock); #1;
        end
        check("drained_valid", col_valid, 1'b0);
        col_ready = 1'b0;

        // Overflow and clear
        wr(2, 16'h0000);
        for (int i = 0; i < 17; i++) wr(0, 16'(16'h1000 + i));
        rd("ovf_status", 1, 16'hC010);
        rd("ovf_counter", 3, 16'h0010);
        wr(1, 16'hFFFF);
        rd("ovf_cleared", 1, 16'h4010);

        // Full with simultaneous pop
        col_ready = 1'b1;
        wr(0, 16'h5555);
        col_ready = 1'b0;
        rd("full_pop_status", 1, 16'h4010);
        rd("full_pop_counter", 3, 16'h0011);

        // Column wrap while draining
        wr(2, 16'h0001);
        rd("flushed", 1, 16'h2000);
        col_ready = 1'b1;
        for (int i = 0; i < 320; i++) wr(0, 16'(i));
        col_ready = 1'b0;
        check("wrap_last_idx", col_index, 9'd319);
        check("wrap_last_dist", col_distance, 16'd319);
        rd("wrap_counter", 3, 16'h0000);
        wr(0, 16'hABCD);
        col_ready = 1'b1;
        @(posedge clock); #1;
        col_ready = 1'b0;
        check("wrap_idx0", col_index, 9'd0);
        check("wrap_dist0", col_distance, 16'hABCD);
        wr(2, 16'h0000);
        rd("clr_keep_status", 1, 16'h0001);
        rd("clr_counter", 3, 16'h0000);
        wr(2, 16'h0001);
        rd("flush_status", 1, 16'h2000);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) wr(0, 16'(16'h0200 + i));
        rd("pre_reset_status", 1, 16'h0005);
        #2;
        reset = 1'b1;
        #1;
        check("async_valid", col_valid, 1'b0);
        check("async_sel", io_select, 1'b0);
        #3;
        reset = 1'b0;
        @(posedge clock); #1;
        rd("post_reset_status", 1, 16'h2000);
        repeat (2) @(posedge clock);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/column_queue.md
Name: column_queue

Overview:
- Memory-mapped store sink directly downstream of the datapath's memory port (memory_address, memory_write_data, plus the controller's write strobe).
- Stores to its address window push ray-cast wall distances into a FIFO, each tagged with an auto-incrementing screen column index.
- The VGA column renderer drains the FIFO through a valid/ready handshake.
- Status and column index are readable back through a registered read port, muxed into memory_read_data by the top level.

Parameters:
- BASE_ADDRESS, 16'hFF00, word address of register 0; the window is BASE_ADDRESS..BASE_ADDRESS+3.
- DEPTH, 16, FIFO entries; power of two, 2..4096.
- COLUMN_COUNT, 320, number of screen columns; column index wraps at this value.
- COLUMN_WIDTH, 9, width of the column index; must hold COLUMN_COUNT-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memory_address  input  16  datapath memory address.
- memory_write_data  input  16  datapath store data.
- memory_write_enable  input  1  store strobe from the controller.
- io_select  output  1  registered: the previous cycle's address was in the window.
- io_read_data  output  16  registered read data for the previous cycle's address.
- col_valid  output  1  FIFO head is valid.
- col_ready  input  1  renderer accepts the head this cycle.
- col_distance  output  16  distance at the FIFO head.
- col_index  output  COLUMN_WIDTH  column tag at the FIFO head.

Behaviour:
- Reset (asynchronous):
  - FIFO is empty; read and write pointers are 0; count is 0.
  - Column counter is 0; overflow is 0.
  - io_select = 0, io_read_data = 0, col_valid = 0.
- Register map, offset from BASE_ADDRESS:
  - Offset 0, write: push. Read returns 0.
  - Offset 1, write: clears overflow (data ignored). Read returns status: bit15 overflow, bit14 full, bit13 empty, bits[12:0] count (zero-extended).
  - Offset 2, write: column counter := 0. If memory_write_data[0] = 1, the FIFO is also flushed (pointers and count go to 0). Read returns 0.
  - Offset 3, write: ignored. Read returns the column counter, zero-extended.
  - Writes outside the window are ignored.
- Push:
  - Accepted when memory_write_enable = 1, address = offset 0, and either count < DEPTH or a pop occurs in the same cycle.
  - An accepted push stores {column counter, memory_write_data}. The column counter then increments, wrapping COLUMN_COUNT-1 -> 0.
  - A refused push (FIFO full, no simultaneous pop) drops the data, sets overflow (sticky), and leaves the counter unchanged.
- Pop:
  - Occurs when col_valid = 1 and col_ready = 1.
  - col_valid = (count != 0).
  - col_distance and col_index are driven combinationally from the entry at the read pointer.
  - The outputs are stable while col_valid = 1 and col_ready = 0.
- Latency:
  - A pushed entry appears on col_* the cycle after the push edge.
  - Read data and io_select appear one cycle after the address is presented, matching synchronous RAM timing.
- Simultaneous push and pop:
  - Count is unchanged and both pointers advance.
  - When full, the push is accepted.
  - When empty, no pop occurs (col_valid = 0) and the push lands.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits and saturates only through the accept rule above.
- Flush in the same cycle as a pop: the flush wins and the FIFO is empty next cycle.
- Status reads reflect state before the edge at which the read is sampled.
- Reset asserted mid-stream discards all entries immediately; col_valid drops without waiting for a clock edge.

Test Plan:
- Reset then idle:
  - col_valid = 0.
  - Read BASE+1 -> io_read_data = 16'h2000 (empty, count 0) and io_select = 1 the next cycle.
- Push 3 and drain:
  - Store 100, 200, 300 to BASE with col_ready = 0.
  - Head = (0, 100); status = 16'h0003.
  - Raise col_ready -> pops (0,100), (1,200), (2,300) on consecutive cycles, then col_valid = 0.
- Overflow and clear:
  - With DEPTH = 16 and col_ready = 0, push 17 words.
  - Status = 16'hC010; column counter reads 16 (the dropped push does not advance it).
  - Write BASE+1 -> status = 16'h4010.
- Full with simultaneous pop:
  - With the FIFO full, hold col_ready = 1 and push in the same cycle.
  - Push is accepted; count stays 16; overflow stays 0.
- Column wrap:
  - With COLUMN_COUNT = 320, push 321 words while draining.
  - Tags run 0..319 then 0.
  - Write BASE+2 with data 0 -> counter reads 0 and FIFO contents are kept.
  - Write BASE+2 with data 1 -> FIFO empties.
- Asynchronous reset mid-stream:
  - Assert reset between edges with 5 entries queued.
  - col_valid falls immediately; after release, status = 16'h2000.
